// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I control sequencer.
// Steps each instruction through fetch/decode/execute/mem/writeback.
module multicycle_control #(
   parameter int EN_MULDIV   = 0,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr,
   input  logic             branch_taken,
   input  logic             muldiv_done,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic             rf_we,
   output logic [1:0]       pc_source,
   output logic [1:0]       rd_source,
   output logic [1:0]       alu_source,
   output logic [4:0]       alu_op,
   output logic             muldiv_start,
   output logic             retire,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   localparam logic [2:0] S_FETCH = 3'd0;
   localparam logic [2:0] S_DEC   = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_MDW   = 3'd3;
   localparam logic [2:0] S_MEM   = 3'd4;
   localparam logic [2:0] S_WB    = 3'd5;
   localparam logic [2:0] S_TRAP  = 3'd6;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_LUI   = 5'd11;
   localparam logic [4:0] ALU_AUIPC = 5'd12;
   localparam logic [4:0] ALU_MUL   = 5'd18;

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_MAX = TW'(MEM_TIMEOUT - 1);

   logic [2:0]    state;
   logic [2:0]    state_n;
   logic [TW-1:0] to_cnt;
   logic          to_hit;
   logic [1:0]    cause;

   logic [6:0] opcode;
   logic [2:0] func3;
   logic [6:0] func7;
   logic [4:0] rd;
   logic       unused_bits;

   logic is_lui, is_auipc, is_jal, is_jalr, is_br;
   logic is_ld, is_st, is_imm, is_op, is_md, legal;
   logic [4:0] dec_op;
   logic [1:0] dec_src;
   logic [1:0] dec_rd;

   assign opcode      = instr[6:0];
   assign rd          = instr[11:7];
   assign func3       = instr[14:12];
   assign func7       = instr[31:25];
   assign unused_bits = ^instr[24:15];

   assign is_lui   = (opcode == OP_LUI);
   assign is_auipc = (opcode == OP_AUIPC);
   assign is_jal   = (opcode == OP_JAL);
   assign is_jalr  = (opcode == OP_JALR);
   assign is_br    = (opcode == OP_BR);
   assign is_ld    = (opcode == OP_LD);
   assign is_st    = (opcode == OP_ST);
   assign is_imm   = (opcode == OP_IMM);
   assign is_op    = (opcode == OP_REG);
   assign is_md    = is_op && (func7 == 7'b0000001);

   assign legal = is_lui | is_auipc | is_jal | is_jalr | is_br
                | is_ld | is_st | is_imm
                | (is_op && (!is_md || (EN_MULDIV != 0)));

   function automatic logic [4:0] arith(input logic [2:0] f3,
                                        input logic alt);
      case (f3)
         3'b000:  arith = alt ? 5'd1 : 5'd0;
         3'b001:  arith = 5'd2;
         3'b010:  arith = 5'd3;
         3'b011:  arith = 5'd4;
         3'b100:  arith = 5'd5;
         3'b101:  arith = alt ? 5'd7 : 5'd6;
         3'b110:  arith = 5'd8;
         default: arith = 5'd9;
      endcase
   endfunction

   function automatic logic [4:0] brop(input logic [2:0] f3);
      case (f3)
         3'b001:  brop = 5'd13;
         3'b100:  brop = 5'd14;
         3'b101:  brop = 5'd15;
         3'b110:  brop = 5'd16;
         3'b111:  brop = 5'd17;
         default: brop = 5'd10;
      endcase
   endfunction

   always_comb begin
      dec_op  = ALU_ADD;
      dec_src = 2'b00;
      dec_rd  = 2'b00;
      unique case (1'b1)
         is_op: begin
            if (is_md) dec_op = ALU_MUL + {2'b00, func3};
            else       dec_op = arith(func3, func7[5]);
         end
         // only shifts-right carry the alternate bit for immediates
         is_imm: begin
            dec_op  = arith(func3, (func3 == 3'b101) && func7[5]);
            dec_src = 2'b01;
         end
         is_lui: begin
            dec_op  = ALU_LUI;
            dec_src = 2'b01;
            dec_rd  = 2'b11;
         end
         is_auipc: begin
            dec_op  = ALU_AUIPC;
            dec_src = 2'b10;
         end
         is_jal: begin
            dec_src = 2'b10;
            dec_rd  = 2'b01;
         end
         is_jalr: begin
            dec_src = 2'b01;
            dec_rd  = 2'b01;
         end
         is_br: dec_op = brop(func3);
         is_ld: begin
            dec_src = 2'b01;
            dec_rd  = 2'b10;
         end
         is_st:   dec_src = 2'b01;
         default: ;
      endcase
   end

   assign to_hit = (to_cnt == TO_MAX);

   always_comb begin
      state_n      = state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      addr_sel     = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      rf_we        = 1'b0;
      muldiv_start = 1'b0;
      retire       = 1'b0;
      pc_source    = 2'b11;
      rd_source    = 2'b00;
      alu_source   = 2'b00;
      alu_op       = ALU_ADD;
      unique case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               state_n = S_DEC;
            end else if (to_hit) begin
               state_n = S_TRAP;
            end
         end
         S_DEC: state_n = legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            alu_op     = dec_op;
            alu_source = dec_src;
            if (is_br) begin
               pc_we     = 1'b1;
               pc_source = branch_taken ? 2'b10 : 2'b11;
               retire    = 1'b1;
               state_n   = S_FETCH;
            end else if (is_ld || is_st) begin
               state_n = S_MEM;
            end else if (is_md) begin
               muldiv_start = 1'b1;
               state_n      = S_MDW;
            end else begin
               state_n = S_WB;
            end
         end
         S_MDW: begin
            alu_op     = dec_op;
            alu_source = dec_src;
            if (muldiv_done) state_n = S_WB;
         end
         S_MEM: begin
            alu_op     = dec_op;
            alu_source = dec_src;
            mem_req    = 1'b1;
            addr_sel   = 1'b1;
            mem_we     = is_st;
            if (mem_ready) begin
               if (is_st) begin
                  pc_we   = 1'b1;
                  retire  = 1'b1;
                  state_n = S_FETCH;
               end else begin
                  state_n = S_WB;
               end
            end else if (to_hit) begin
               state_n = S_TRAP;
            end
         end
         S_WB: begin
            rf_we     = (rd != 5'd0);
            rd_source = dec_rd;
            pc_we     = 1'b1;
            pc_source = is_jal ? 2'b01 : (is_jalr ? 2'b00 : 2'b11);
            retire    = 1'b1;
            state_n   = S_FETCH;
         end
         default: state_n = state;
      endcase
      // strobes fall with reset, without waiting for a clock
      if (!rst_n) begin
         mem_req      = 1'b0;
         mem_we       = 1'b0;
         addr_sel     = 1'b0;
         ir_we        = 1'b0;
         pc_we        = 1'b0;
         rf_we        = 1'b0;
         muldiv_start = 1'b0;
         retire       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         to_cnt  <= '0;
         cause   <= 2'b00;
         instret <= '0;
      end else begin
         state <= state_n;
         if (state_n != state)
            to_cnt <= '0;
         else if (mem_req && !mem_ready)
            to_cnt <= to_cnt + 1'b1;
         if (state == S_DEC && !legal)
            cause <= 2'b01;
         else if (state_n == S_TRAP && state != S_TRAP)
            cause <= 2'b10;
         if (retire)
            instret <= instret + 1'b1;
      end
   end

   assign trap       = (state == S_TRAP);
   assign trap_cause = cause;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the combinational RV32I decode/control block.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives datapath mux selects, register enables and a req/ready memory handshake.
- Adds optional M-extension decode with a multi-cycle ALU wait, a memory timeout trap, illegal-instruction trap and a retired-instruction counter.

Parameters:
- EN_MULDIV, 0: 1 decodes OP_REG with func7=0000001 as MUL/DIV family; 0 treats it as illegal.
- MEM_TIMEOUT, 255: max cycles mem_req may stay unacknowledged before trap; must be ≥1.
- CNT_W, 32: width of instret counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  instruction register contents; valid from DECODE onward.
- branch_taken  in  1  ALU compare result, valid in EXECUTE.
- muldiv_done  in  1  multi-cycle ALU completion pulse.
- mem_ready  in  1  memory acknowledge.
- mem_req  out  1  memory request.
- mem_we  out  1  store request qualifier.
- addr_sel  out  1  0=PC, 1=ALU result drives memory address.
- ir_we  out  1  load instr register.
- pc_we  out  1  update PC.
- rf_we  out  1  register-file write.
- pc_source  out  2  00 ALU(jalr), 01 PC+immJ, 10 PC+immB, 11 PC+4.
- rd_source  out  2  00 ALU, 01 PC+4, 10 memory, 11 immediate.
- alu_source  out  2  00 rs1/rs2, 01 rs1/imm, 10 PC/imm.
- alu_op  out  5  ALU op code, encoding below.
- muldiv_start  out  1  one-cycle start pulse.
- retire  out  1  one-cycle pulse per completed instruction.
- trap  out  1  sticky error.
- trap_cause  out  2  00 none, 01 illegal, 10 mem timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH; all enables, strobes and trap cleared.
  - trap_cause=00, instret=0, timeout counter=0.
  - Selects: pc_source=11, rd_source=00, alu_source=00, alu_op=ADD.
  - Reset mid-transaction drops mem_req immediately; no pending request survives.
- States: FETCH, DECODE, EXECUTE, MULDIV_WAIT, MEM, WRITEBACK, TRAP.
- Handshake:
  - A transfer completes in any cycle with mem_req=1 and mem_ready=1.
  - mem_req, mem_we and addr_sel stay stable until that cycle.
  - mem_ready while mem_req=0 is ignored.
- FETCH:
  - mem_req=1, addr_sel=0.
  - On transfer: ir_we=1 that cycle, go to DECODE.
- DECODE:
  - Classify opcode. Unknown opcode, or func7=0000001 on OP_REG with EN_MULDIV=0, goes to TRAP with cause 01.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - Selects follow the single-cycle decode: alu_op per func3/func7 and alu_source per opcode.
  - Load/store: alu_source=01, alu_op=ADD.
  - Routing:
    - Branch: pc_we=1, pc_source=10 if branch_taken else 11, retire; go to FETCH.
    - Load/store: go to MEM.
    - MUL/DIV: muldiv_start=1, go to MULDIV_WAIT.
    - All other instructions: go to WRITEBACK.
- MULDIV_WAIT:
  - Hold alu_op.
  - On muldiv_done go to WRITEBACK.
  - No timeout applies here.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for stores.
  - On transfer: loads go to WRITEBACK; stores do pc_we=1 (pc_source=11), retire, and go to FETCH.
- WRITEBACK:
  - rf_we=1 unless rd=0, with rd_source per opcode.
  - pc_we=1 with pc_source 01 (JAL), 00 (JALR), else 11.
  - retire=1, go to FETCH. Duration is exactly 1 cycle.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 BEQ, 11 LUI, 12 AUIPC, 13 BNE, 14 BLT, 15 BGE, 16 BLTU, 17 BGEU.
  - 18–25 MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (func3 order).
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 without mem_ready.
  - When it reaches MEM_TIMEOUT without a transfer: go to TRAP with cause 10 and drop mem_req.
  - mem_ready in the same cycle the limit is reached counts as a transfer; no trap.
- TRAP:
  - All strobes are 0, trap=1. Exit only by reset.
- instret:
  - Increments on retire and wraps modulo 2^CNT_W.
- Latency:
  - ALU/LUI/AUIPC/JAL(R): 4 cycles with zero-wait memory.
  - Branch: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready always 1 → ir_we @c0, alu_op=0, alu_source=00 @c2, rf_we+retire+pc_we(11) @c3, instret=1.
- LW x5,4(x1) with mem_ready delayed 3 cycles in MEM → mem_req held stable 4 cycles, addr_sel=1, rd_source=10 in WRITEBACK, total 8 cycles.
- BEQ (0x00208463) with branch_taken=1, then 0 → pc_source=10, then 11; retire at cycle 2; rf_we never asserted.
- EN_MULDIV=1, MUL (0x022081B3), muldiv_done 5 cycles after start → alu_op=18, one muldiv_start pulse, WRITEBACK one cycle after done. With EN_MULDIV=0 → trap=1, cause=01, no retire.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → mem_req high 4 cycles then 0, trap=1, cause=10. Repeat with ready at cycle 4 → no trap.
- Assert rst_n=0 in MEM mid-wait → mem_req drops asynchronously; after release, FETCH with instret=0. Also CNT_W=4, 16 retires → instret wraps to 0.
